signal_conditioner: RTL
=======================

# signal_conditioner

Parametrised multi-channel input conditioner: the successor to the single-purpose inverter. Each of WIDTH channels is synchronised into `clk`, optionally inverted by a per-channel mask, and glitch-filtered. The block produces a filtered level, one-cycle rise and fall pulses, and a mode-selected output. It sits at the boundary of the final system, between asynchronous external/control inputs and the synchronous core logic.

## Interface
- `WIDTH`, default 1: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flop depth (≥2).
- `FILT_LEN`, default 4: consecutive stable cycles required to accept a new level (≥1). Counter width is max(1, $clog2(FILT_LEN)).
- `clk` input, 1 bit: single system clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `in_signal` input, WIDTH bits: raw asynchronous channel inputs.
- `invert_mask` input, WIDTH bits: 1 inverts that channel. Synchronous to `clk`, may change at any time.
- `mode` input, 2 bits: `out_signal` select, quasi-static.
- `inverted_signal` output, WIDTH bits: filtered, polarity-corrected level.
- `rise_pulse` output, WIDTH bits: one-cycle pulse on each 0→1 of `inverted_signal`.
- `fall_pulse` output, WIDTH bits: one-cycle pulse on each 1→0 of `inverted_signal`.
- `out_signal` output, WIDTH bits: mode-selected view.

## Operation
- Per-channel pipeline: SYNC_STAGES-flop synchroniser → XOR with `invert_mask` (cond) → glitch filter → edge register.
- Filter state per channel: `filt` level and counter `cnt`.
  - cond == filt: cnt ← 0.
  - cond != filt and cnt == FILT_LEN-1: filt ← cond, cnt ← 0.
  - Otherwise cnt ← cnt+1.
  - Any return of cond to filt before acceptance restarts the count.
- Pulses: on the edge where filt changes 0→1, rise_pulse ← 1. On the edge where it changes 1→0, fall_pulse ← 1. Otherwise both ← 0. Pulses are concurrent with the new `inverted_signal` value and last exactly 1 cycle.
- `out_signal` is combinational from registered state:
  - MODE_LEVEL (00): `inverted_signal`.
  - MODE_RISE (01): `rise_pulse`.
  - MODE_FALL (10): `fall_pulse`.
  - MODE_ANY (11): `rise_pulse | fall_pulse`.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- A mask change is treated exactly as an input change. It is filtered and produces the corresponding pulse.

## Timing
- Reset: all synchroniser flops, filt, cnt, rise_pulse and fall_pulse are 0. All outputs are 0 while `rst` is high, regardless of `mode`.
- `in_signal` latency: a level stable before edge 0 appears on `inverted_signal` after edge SYNC_STAGES+FILT_LEN-1. For the defaults this is edge 5, i.e. 6 edges inclusive.
- `invert_mask` latency: FILT_LEN edges, with no synchroniser delay.
- FILT_LEN=1: no filtering. filt follows cond with 1 cycle of delay.
- Reset after power-up with `invert_mask`=1 on a channel: that channel's filt rises after the filter delay and emits one rise_pulse. This is required behaviour, not suppressed.
- Reset asserted mid-count: state clears immediately. No pulse is emitted for the aborted transition after release.
- `mode` change takes effect in the same cycle on `out_signal`.

## Structure
- Shared package `signal_conditioner_pkg`:
  - localparams MODE_LEVEL, MODE_RISE, MODE_FALL, MODE_ANY (2-bit).
  - Counter-width function.
- Sub-module `glitch_filter`: one channel holding filt, cnt and the edge register, with parameter FILT_LEN. Instantiated WIDTH times in a generate loop.
- Synchroniser, mask XOR and mode mux live in the top module.

## Test plan
All scenarios use WIDTH=4, SYNC_STAGES=2, FILT_LEN=4.
- Reset: hold `rst`=1 with in_signal=4'hF, mode=11 → all outputs 4'h0. Release with in=0, mask=0 → outputs stay 4'h0 for 20 cycles.
- Clean edge: in_signal[0] 0→1 before edge 0 → `inverted_signal`=4'h1 and `rise_pulse`=4'h1 after edge 5, rise_pulse back to 0 after edge 6. Return to 0 → fall_pulse=4'h1 for 1 cycle.
- Glitch: 3-cycle high on in_signal[1] → `inverted_signal`[1] stays 0 and no pulses. A 4-cycle high is accepted.
- Mask: in=4'h0, mask 4'h0→4'hA before edge 0 → `inverted_signal`=4'hA and `rise_pulse`=4'hA after edge 3, for 1 cycle.
- Mode: mode=11, toggle in_signal[2] high then low → `out_signal`[2] pulses once per edge. mode=00 → `out_signal` equals `inverted_signal` in the same cycle.
- Reset mid-filter: assert `rst` when ch3 cnt=2 → outputs 0 asynchronously. After release with input low, no pulse on ch3.

Source files
------------

// File: rtl/signal_conditioner_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signal_conditioner_pkg
// Output-mode encodings and filter counter sizing for signal_conditioner.
// Revision: 1.0
// ---------------------------------------------------------------------------
package signal_conditioner_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_ANY   = 2'b11;

  // A FILT_LEN of 1 still needs a one-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int filt_len);
    int w;
    w = $clog2(filt_len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : signal_conditioner_pkg
`default_nettype wire

// File: rtl/glitch_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glitch_filter
// One channel: accepts a new level after FILT_LEN stable cycles, registers edges.
// Revision: 1.0
// ---------------------------------------------------------------------------
module glitch_filter
  import signal_conditioner_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cond,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW        = cnt_width(FILT_LEN);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(FILT_LEN - 1);

  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (cond == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
        // Pulses land in the same cycle as the new level.
        r_filt <= cond;
        r_cnt  <= '0;
        r_rise <= cond;
        r_fall <= ~cond;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_filt;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule : glitch_filter
`default_nettype wire

// File: rtl/signal_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signal_conditioner
// Multi-channel synchroniser, polarity mask, glitch filter and edge/mode output.
// Revision: 1.0
// ---------------------------------------------------------------------------
module signal_conditioner
  import signal_conditioner_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_signal,
  input  logic [WIDTH-1:0] invert_mask,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] inverted_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] out_signal
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_signal;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // The mask bypasses the synchroniser: it is already in the clk domain.
  assign w_cond = r_sync[SYNC_STAGES-1] ^ invert_mask;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      glitch_filter #(
        .FILT_LEN(FILT_LEN)
      ) u_filt (
        .clk  (clk),
        .rst  (rst),
        .cond (w_cond[g]),
        .level(inverted_signal[g]),
        .rise (rise_pulse[g]),
        .fall (fall_pulse[g])
      );
    end
  endgenerate

  always_comb begin
    out_signal = '0;
    case (mode)
      MODE_LEVEL: out_signal = inverted_signal;
      MODE_RISE:  out_signal = rise_pulse;
      MODE_FALL:  out_signal = fall_pulse;
      MODE_ANY:   out_signal = rise_pulse | fall_pulse;
      default:    out_signal = '0;
    endcase
  end

endmodule : signal_conditioner
`default_nettype wire
